vga_box_renderer: RTL and testbench

//  Pixel stage directly downstream of the VGA timing decoder. It consumes DE, h_sync, v_sync, x_pixel and y_pixel.

---
 rtl/vga_pkg.sv | 61 ++++++
 rtl/box_motion_ctrl.sv | 65 ++++++
 rtl/vga_box_renderer.sv | 107 ++++++++++
 tb/tb_vga_box_renderer.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing constants, colour/direction types and the per-axis bounce rule
// used by the box renderer.
package vga_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_FRONT  = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BACK   = 48;
    localparam int H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;

    localparam int V_ACTIVE = 480;
    localparam int V_FRONT  = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BACK   = 33;
    localparam int V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    // Wide enough that position + size + speed never wraps on either axis.
    localparam int POS_W = 11;

    typedef struct packed {
        logic [3:0] red;
        logic [3:0] green;
        logic [3:0] blue;
    } rgb444_t;

    typedef enum logic {
        DIR_POS = 1'b0,
        DIR_NEG = 1'b1
    } dir_t;

    typedef struct packed {
        logic [POS_W-1:0] pos;
        dir_t             dir;
    } axis_t;

    // One frame of motion on one axis: clamp to the wall and reverse on contact.
    function automatic axis_t axis_step(input axis_t            cur,
                                        input logic [POS_W-1:0] size,
                                        input logic [POS_W-1:0] limit,
                                        input logic [POS_W-1:0] speed);
        axis_t nxt;
        nxt = cur;
        if (cur.dir == DIR_POS) begin
            if (cur.pos + size + speed > limit) begin
                nxt.pos = limit - size;
                nxt.dir = DIR_NEG;
            end else begin
                nxt.pos = cur.pos + speed;
            end
        end else begin
            if (cur.pos < speed) begin
                nxt.pos = '0;
                nxt.dir = DIR_POS;
            end else begin
                nxt.pos = cur.pos - speed;
            end
        end
        return nxt;
    endfunction

endpackage

// File: rtl/box_motion_ctrl.sv
// Frame-rate box motion: detects the start of vertical sync, pulses frame_tick and
// steps the box position/direction once per frame.
module box_motion_ctrl
    import vga_pkg::*;
#(
    parameter int BOX_W = 64,
    parameter int BOX_H = 48,
    parameter int SPEED = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pix_en,
    input  logic       v_sync_in,
    input  logic       move_en,
    output logic [9:0] box_x,
    output logic [8:0] box_y,
    output logic       frame_tick
);

    localparam logic [POS_W-1:0] BOX_W_C    = POS_W'(BOX_W);
    localparam logic [POS_W-1:0] BOX_H_C    = POS_W'(BOX_H);
    localparam logic [POS_W-1:0] H_ACTIVE_C = POS_W'(H_ACTIVE);
    localparam logic [POS_W-1:0] V_ACTIVE_C = POS_W'(V_ACTIVE);
    localparam logic [POS_W-1:0] SPEED_C    = POS_W'(SPEED);

    logic  prev_vs_q;
    logic  tick_q;
    logic  vs_fall;
    axis_t x_q, x_d;
    axis_t y_q, y_d;

    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        vs_fall = pix_en && prev_vs_q && !v_sync_in;
        x_d     = x_q;
        y_d     = y_q;
        if (vs_fall && move_en) begin
            x_d = axis_step(x_q, BOX_W_C, H_ACTIVE_C, SPEED_C);
            y_d = axis_step(y_q, BOX_H_C, V_ACTIVE_C, SPEED_C);
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_vs_q <= 1'b1;
            tick_q    <= 1'b0;
            x_q       <= '{pos: '0, dir: DIR_POS};
            y_q       <= '{pos: '0, dir: DIR_POS};
        end else begin
            // The tick is a single clk wide even though the edge is sampled at pixel rate.
            tick_q <= vs_fall;
            x_q    <= x_d;
            y_q    <= y_d;
            if (pix_en) begin
                prev_vs_q <= v_sync_in;
            end
        end
    end

    assign box_x      = x_q.pos[9:0];
    assign box_y      = y_q.pos[8:0];
    assign frame_tick = tick_q;

endmodule

// File: rtl/vga_box_renderer.sv
// Two-stage pixel pipeline drawing a switch-coloured bouncing box over a fixed
// background; syncs travel alongside RGB so the outputs can drive the connector.
module vga_box_renderer
    import vga_pkg::*;
#(
    parameter int          BOX_W  = 64,
    parameter int          BOX_H  = 48,
    parameter int          SPEED  = 2,
    parameter logic [11:0] BG_RGB = 12'h008
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pix_en,
    input  logic       de_in,
    input  logic       h_sync_in,
    input  logic       v_sync_in,
    input  logic [9:0] x_pixel,
    input  logic [8:0] y_pixel,
    input  logic       move_en,
    input  logic [3:0] sw_red,
    input  logic [3:0] sw_green,
    input  logic [3:0] sw_blue,
    output logic       h_sync,
    output logic       v_sync,
    output logic [3:0] red_port,
    output logic [3:0] green_port,
    output logic [3:0] blue_port,
    output logic       frame_tick
);

    localparam logic [POS_W-1:0] BOX_W_C = POS_W'(BOX_W);
    localparam logic [POS_W-1:0] BOX_H_C = POS_W'(BOX_H);
    localparam rgb444_t          BG      = rgb444_t'(BG_RGB);

    logic [9:0] box_x;
    logic [8:0] box_y;

    box_motion_ctrl #(
        .BOX_W (BOX_W),
        .BOX_H (BOX_H),
        .SPEED (SPEED)
    ) u_motion (
        .clk        (clk),
        .reset      (reset),
        .pix_en     (pix_en),
        .v_sync_in  (v_sync_in),
        .move_en    (move_en),
        .box_x      (box_x),
        .box_y      (box_y),
        .frame_tick (frame_tick)
    );

    logic [POS_W-1:0] x_ext, y_ext, bx_ext, by_ext;
    logic             hit_d;
    rgb444_t          rgb_d;

    logic    de_s1_q, hs_s1_q, vs_s1_q, hit_s1_q;
    logic    hs_q, vs_q;
    rgb444_t rgb_q;

    always_comb begin
        x_ext  = POS_W'(x_pixel);
        y_ext  = POS_W'(y_pixel);
        bx_ext = POS_W'(box_x);
        by_ext = POS_W'(box_y);
        hit_d  = de_in
              && (x_ext >= bx_ext) && (x_ext < bx_ext + BOX_W_C)
              && (y_ext >= by_ext) && (y_ext < by_ext + BOX_H_C);
    end

    // Switches are quasi-static, so they are read directly in the output stage.
    always_comb begin
        rgb_d = '0;
        if (hit_s1_q) begin
            rgb_d = '{red: sw_red, green: sw_green, blue: sw_blue};
        end else if (de_s1_q) begin
            rgb_d = BG;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            de_s1_q  <= 1'b0;
            hs_s1_q  <= 1'b1;
            vs_s1_q  <= 1'b1;
            hit_s1_q <= 1'b0;
            hs_q     <= 1'b1;
            vs_q     <= 1'b1;
            rgb_q    <= '0;
        end else if (pix_en) begin
            de_s1_q  <= de_in;
            hs_s1_q  <= h_sync_in;
            vs_s1_q  <= v_sync_in;
            hit_s1_q <= hit_d;
            hs_q     <= hs_s1_q;
            vs_q     <= vs_s1_q;
            rgb_q    <= rgb_d;
        end
    end

    assign h_sync     = hs_q;
    assign v_sync     = vs_q;
    assign red_port   = rgb_q.red;
    assign green_port = rgb_q.green;
    assign blue_port  = rgb_q.blue;

endmodule

// File: tb/tb_vga_box_renderer.sv
// Randomised self-checking bench for vga_box_renderer against a behavioural pixel/motion model.
module tb_vga_box_renderer;

    localparam int SPEED = 2;
    localparam int HA    = 640;
    localparam int VA    = 480;

    logic       clk = 1'b0;
    logic       reset, pix_en, de_in, h_sync_in, v_sync_in, move_en;
    logic [9:0] x_pixel;
    logic [8:0] y_pixel;
    logic [3:0] sw_red, sw_green, sw_blue;

    logic       a_hs, a_vs, a_tick, b_hs, b_vs, b_tick, c_hs, c_vs, c_tick;
    logic [3:0] a_r, a_g, a_b, b_r, b_g, b_b, c_r, c_g, c_b;
    logic [11:0] a_rgb;
    logic [11:0] a_xq, a_yq, b_xq, c_xq, c_yq;

    always #5 clk = ~clk;

    vga_box_renderer #(.BOX_W(64), .BOX_H(48), .SPEED(SPEED), .BG_RGB(12'h008)) dut_a (
        .clk(clk), .reset(reset), .pix_en(pix_en), .de_in(de_in), .h_sync_in(h_sync_in),
        .v_sync_in(v_sync_in), .x_pixel(x_pixel), .y_pixel(y_pixel), .move_en(move_en),
        .sw_red(sw_red), .sw_green(sw_green), .sw_blue(sw_blue), .h_sync(a_hs), .v_sync(a_vs),
        .red_port(a_r), .green_port(a_g), .blue_port(a_b), .frame_tick(a_tick));

    vga_box_renderer #(.BOX_W(637), .BOX_H(48), .SPEED(SPEED), .BG_RGB(12'h008)) dut_b (
        .clk(clk), .reset(reset), .pix_en(pix_en), .de_in(de_in), .h_sync_in(h_sync_in),
        .v_sync_in(v_sync_in), .x_pixel(x_pixel), .y_pixel(y_pixel), .move_en(move_en),
        .sw_red(sw_red), .sw_green(sw_green), .sw_blue(sw_blue), .h_sync(b_hs), .v_sync(b_vs),
        .red_port(b_r), .green_port(b_g), .blue_port(b_b), .frame_tick(b_tick));

    vga_box_renderer #(.BOX_W(640), .BOX_H(480), .SPEED(SPEED), .BG_RGB(12'h008)) dut_c (
        .clk(clk), .reset(reset), .pix_en(pix_en), .de_in(de_in), .h_sync_in(h_sync_in),
        .v_sync_in(v_sync_in), .x_pixel(x_pixel), .y_pixel(y_pixel), .move_en(move_en),
        .sw_red(sw_red), .sw_green(sw_green), .sw_blue(sw_blue), .h_sync(c_hs), .v_sync(c_vs),
        .red_port(c_r), .green_port(c_g), .blue_port(c_b), .frame_tick(c_tick));

    assign a_rgb = {a_r, a_g, a_b};
    // Axis state is {pos[10:0], dir}; dir 1 means moving towards zero.
    assign a_xq = dut_a.u_motion.x_q;
    assign a_yq = dut_a.u_motion.y_q;
    assign b_xq = dut_b.u_motion.x_q;
    assign c_xq = dut_c.u_motion.x_q;
    assign c_yq = dut_c.u_motion.y_q;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        bit de;
        bit hs;
        bit vs;
        bit hit;
    } pix_t;

    pix_t        hist[$];
    logic [11:0] exp_rgb;
    bit          exp_hs, exp_vs, m_prev_vs;
    int          m_ticks, obs_ticks;
    int          mx[3], my[3], bw[3], bh[3];
    bit          mnx[3], mny[3];

    function automatic int next_pos(int pos, bit neg, int size, int limit);
        if (!neg) return (pos + size + SPEED > limit) ? limit - size : pos + SPEED;
        return (pos < SPEED) ? 0 : pos - SPEED;
    endfunction

    function automatic bit next_neg(int pos, bit neg, int size, int limit);
        if (!neg) return (pos + size + SPEED > limit);
        return !(pos < SPEED);
    endfunction

    task automatic model_reset();
        pix_t r;
        r.de = 0; r.hs = 1; r.vs = 1; r.hit = 0;
        hist.delete();
        hist.push_back(r);
        exp_rgb = 12'h000; exp_hs = 1; exp_vs = 1; m_prev_vs = 1; m_ticks = 0;
        for (int i = 0; i < 3; i++) begin
            mx[i] = 0; my[i] = 0; mnx[i] = 0; mny[i] = 0;
        end
    endtask

    task automatic check_pos();
        check("a_x", 32'(a_xq[11:1]), mx[0]);
        check("a_dx", 32'(a_xq[0]), 32'(mnx[0]));
        check("a_y", 32'(a_yq[11:1]), my[0]);
        check("a_dy", 32'(a_yq[0]), 32'(mny[0]));
        check("b_x", 32'(b_xq[11:1]), mx[1]);
        check("b_dx", 32'(b_xq[0]), 32'(mnx[1]));
        check("c_x", 32'(c_xq[11:1]), mx[2]);
        check("c_dx", 32'(c_xq[0]), 32'(mnx[2]));
        check("c_y", 32'(c_yq[11:1]), my[2]);
        check("c_dy", 32'(c_yq[0]), 32'(mny[2]));
    endtask

    // One pixel strobe on the current inputs, then three idle clocks (1-in-4 pixel rate).
    task automatic strobe();
        pix_t        e, n;
        bit          tick;
        logic [11:0] sw;
        int          px, py;
        @(negedge clk);
        pix_en = 1'b1;
        e  = hist.pop_front();
        sw = {sw_red, sw_green, sw_blue};
        exp_rgb = e.hit ? sw : (e.de ? 12'h008 : 12'h000);
        exp_hs  = e.hs;
        exp_vs  = e.vs;
        px = int'(x_pixel);
        py = int'(y_pixel);
        n.de  = de_in; n.hs = h_sync_in; n.vs = v_sync_in;
        n.hit = de_in && px >= mx[0] && px < mx[0] + bw[0] && py >= my[0] && py < my[0] + bh[0];
        hist.push_back(n);
        tick = m_prev_vs && !v_sync_in;
        m_prev_vs = v_sync_in;
        if (tick) begin
            m_ticks++;
            if (move_en) begin
                for (int i = 0; i < 3; i++) begin
                    int ox, oy;
                    ox = mx[i]; oy = my[i];
                    mx[i]  = next_pos(ox, mnx[i], bw[i], HA);
                    mnx[i] = next_neg(ox, mnx[i], bw[i], HA);
                    my[i]  = next_pos(oy, mny[i], bh[i], VA);
                    mny[i] = next_neg(oy, mny[i], bh[i], VA);
                end
            end
        end
        @(posedge clk); #1;
        pix_en = 1'b0;
        check("rgb", 32'(a_rgb), 32'(exp_rgb));
        check("h_sync", 32'(a_hs), 32'(exp_hs));
        check("v_sync", 32'(a_vs), 32'(exp_vs));
        check("tick_a", 32'(a_tick), 32'(tick));
        check("tick_b", 32'(b_tick), 32'(tick));
        check("tick_c", 32'(c_tick), 32'(tick));
        if (a_tick) obs_ticks++;
        check_pos();
        @(posedge clk); #1;
        check("tick_width", 32'(a_tick), 0);
        check("rgb_hold", 32'(a_rgb), 32'(exp_rgb));
        check("hs_hold", 32'(a_hs), 32'(exp_hs));
        @(posedge clk); #1;
        @(posedge clk); #1;
    endtask

    task automatic rand_pixel();
        int xr, yr;
        xr = mx[0] + int'($urandom_range(0, 90)) - 12;
        yr = my[0] + int'($urandom_range(0, 70)) - 10;
        if (xr < 0) xr = 0;
        if (xr > HA - 1) xr = HA - 1;
        if (yr < 0) yr = 0;
        if (yr > VA - 1) yr = VA - 1;
        x_pixel   = 10'(xr);
        y_pixel   = 9'(yr);
        de_in     = 1'($urandom_range(0, 3) != 0);
        h_sync_in = 1'($urandom_range(0, 1));
        sw_red    = 4'($urandom);
        sw_green  = 4'($urandom);
        sw_blue   = 4'($urandom);
    endtask

    // Compressed frame: vsync falls on the second strobe.
    task automatic frame();
        v_sync_in = 1'b1; rand_pixel(); strobe();
        v_sync_in = 1'b0; rand_pixel(); strobe();
        rand_pixel(); strobe();
        v_sync_in = 1'b1; rand_pixel(); strobe();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int hold_x, hold_y;
        bw[0] = 64;  bh[0] = 48;
        bw[1] = 637; bh[1] = 48;
        bw[2] = 640; bh[2] = 480;
        reset = 1'b0; pix_en = 1'b0; de_in = 1'b0; h_sync_in = 1'b1; v_sync_in = 1'b1;
        x_pixel = '0; y_pixel = '0; move_en = 1'b1;
        sw_red = 4'hF; sw_green = 4'h0; sw_blue = 4'hA;
        obs_ticks = 0;

        // Reset held while inputs toggle: outputs must stay at reset values.
        for (int i = 0; i < 24; i++) begin
            @(posedge clk); #1;
            pix_en    = (i % 4 == 0);
            h_sync_in = 1'($urandom_range(0, 1));
            v_sync_in = 1'($urandom_range(0, 1));
            de_in     = 1'($urandom_range(0, 1));
            x_pixel   = 10'($urandom_range(0, 100));
            check("rst_hs", 32'(a_hs), 1);
            check("rst_vs", 32'(a_vs), 1);
            check("rst_rgb", 32'(a_rgb), 0);
            check("rst_tick", 32'(a_tick), 0);
        end
        pix_en = 1'b0; h_sync_in = 1'b1; v_sync_in = 1'b1; de_in = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        model_reset();

        // Latency on a box pixel at (0,0), then the background just right of the box.
        sw_red = 4'hF; sw_green = 4'h0; sw_blue = 4'hA;
        de_in = 1'b1; x_pixel = 10'd10; y_pixel = 9'd10;
        strobe();
        check("lat_early", 32'(a_rgb), 32'h000);
        strobe();
        check("lat_box", 32'(a_rgb), 32'hF0A);
        x_pixel = 10'd64;
        strobe();
        strobe();
        check("edge_bg", 32'(a_rgb), 32'h008);

        // Hsync pulse train through the pipeline.
        de_in = 1'b0;
        for (int i = 0; i < 96; i++) begin
            h_sync_in = 1'((i % 16) >= 5);
            strobe();
        end

        // 300 moving frames with randomised pixels around the box.
        for (int f = 0; f < 300; f++) begin
            frame();
            if (m_ticks == 288) check("x_at_288", 32'(a_xq[11:1]), 576);
            if (m_ticks == 289) check("dirx_flip", 32'(a_xq[0]), 1);
            if (m_ticks == 290) check("x_first_dec", 32'(a_xq[11:1]), 574);
            if (m_ticks == 216) check("y_at_216", 32'(a_yq[11:1]), 432);
            if (m_ticks == 217) check("diry_flip", 32'(a_yq[0]), 1);
            if (m_ticks == 218) check("y_first_dec", 32'(a_yq[11:1]), 430);
            if (m_ticks == 4)   check("b_clamp0", 32'(b_xq), 32'h000);
            if (m_ticks == 5)   check("b_after0", 32'(b_xq[11:1]), 2);
            if (m_ticks == 1)   check("c_full_neg", 32'(c_xq), 32'h001);
            if (m_ticks == 2)   check("c_full_pos", 32'(c_xq), 32'h000);
        end

        // Motion disabled: ticks continue, position holds.
        move_en   = 1'b0;
        hold_x    = mx[0];
        hold_y    = my[0];
        obs_ticks = 0;
        for (int f = 0; f < 5; f++) frame();
        check("hold_ticks", obs_ticks, 5);
        check("hold_x", 32'(a_xq[11:1]), hold_x);
        check("hold_y", 32'(a_yq[11:1]), hold_y);

        // pix_en held low: nothing moves or ticks whatever the inputs do.
        move_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            v_sync_in = 1'($urandom_range(0, 1));
            h_sync_in = 1'($urandom_range(0, 1));
            de_in     = 1'($urandom_range(0, 1));
            check("frz_tick", 32'(a_tick), 0);
            check("frz_rgb", 32'(a_rgb), 32'(exp_rgb));
            check("frz_hs", 32'(a_hs), 32'(exp_hs));
        end
        v_sync_in = 1'b1;
        check_pos();

        // Asynchronous reset mid-frame, then the first tick from the origin.
        de_in = 1'b1; x_pixel = 10'(mx[0] + 2); y_pixel = 9'(my[0] + 2);
        strobe();
        strobe();
        @(posedge clk); #3;
        reset = 1'b0;
        #1;
        check("amid_rgb", 32'(a_rgb), 0);
        check("amid_hs", 32'(a_hs), 1);
        check("amid_vs", 32'(a_vs), 1);
        check("amid_x", 32'(a_xq), 0);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        frame();
        check("post_rst_x", 32'(a_xq[11:1]), SPEED);
        check("post_rst_y", 32'(a_yq[11:1]), SPEED);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
